add4_accumulator: RTL and testbench

ADD4_ACCUMULATOR -- requirements
Module: add4_accumulator

---
 rtl/add4_acc_pkg.sv | 14 +
 rtl/add4_accumulator_ripple.sv | 27 ++
 rtl/add4_accumulator.sv | 117 +++++++++++
 tb/tb_add4_accumulator.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/add4_acc_pkg.sv
// Shared types and widths for the 4-bit group accumulator.
// Optional feature macro: ADD4_ACC_OVF_EN (sticky group overflow on out_ovf).
package add4_acc_pkg;

  localparam int DATA_W = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/add4_accumulator_ripple.sv
// Combinational DATA_W-bit ripple-carry adder (module ripple_add4_core).
// Each stage keeps its carry in its own net so the chain has no self-referencing vector.
module ripple_add4_core
  import add4_acc_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] sum,
  output logic              cout
);

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit
    logic c_in;
    logic c_out;
    if (gi == 0) begin : g_first
      assign c_in = cin;
    end else begin : g_chain
      assign c_in = g_bit[gi-1].c_out;
    end
    assign sum[gi] = a[gi] ^ b[gi] ^ c_in;
    assign c_out   = (a[gi] & b[gi]) | (c_in & (a[gi] ^ b[gi]));
  end

  assign cout = g_bit[DATA_W-1].c_out;

endmodule

// File: rtl/add4_accumulator.sv
// Sums groups of 4-bit operands (closed by in_last or MAX_TERMS) and presents one result per group.
// Optional feature macro: ADD4_ACC_OVF_EN builds the sticky carry register driving out_ovf.
module add4_accumulator
  import add4_acc_pkg::*;
#(
  parameter int MAX_TERMS = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_cout,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  state_t            state_reg;
  state_t            state_next;
  logic [DATA_W-1:0] acc_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              last_carry_reg;

  logic [DATA_W-1:0] add_sum;
  logic              add_cout;
  logic [CNT_W-1:0]  count_next;
  logic              closing;
  logic              in_fire;
  logic              out_fire;

  ripple_add4_core u_adder (
    .a    (acc_reg),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign count_next = count_reg + CNT_W'(1);
  // Count is zero in IDLE, so this also closes the first beat when MAX_TERMS is 1.
  assign closing    = in_last || (count_next == CNT_W'(MAX_TERMS));
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE, ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = closing ? DONE : ACCUM;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Accumulator state doubles as the result registers; it is frozen in DONE and cleared on handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg        <= '0;
      count_reg      <= '0;
      last_carry_reg <= 1'b0;
    end else if (out_fire) begin
      acc_reg        <= '0;
      count_reg      <= '0;
      last_carry_reg <= 1'b0;
    end else if (in_fire) begin
      acc_reg        <= add_sum;
      count_reg      <= count_next;
      last_carry_reg <= add_cout;
    end
  end

  assign out_sum   = acc_reg;
  assign out_cout  = last_carry_reg;
  assign out_count = count_reg;

`ifdef ADD4_ACC_OVF_EN
  logic sticky_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_reg <= 1'b0;
    end else if (out_fire) begin
      sticky_reg <= 1'b0;
    end else if (in_fire) begin
      sticky_reg <= sticky_reg | add_cout;
    end
  end

  assign out_ovf = sticky_reg;
`else
  assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_add4_accumulator.sv
// Directed self-checking bench for add4_accumulator (default MAX_TERMS = 15).
// Expected out_ovf follows ADD4_ACC_OVF_EN when the bench is built with it.
module tb_add4_accumulator;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_sum;
  logic       out_cout;
  logic [3:0] out_count;
  logic       out_ovf;

  int checks   = 0;
  int failures = 0;

`ifdef ADD4_ACC_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  add4_accumulator #(.MAX_TERMS(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at #1 after a rising edge; returns at #1 after the accepting edge.
  task automatic send(input logic [3:0] d, input logic l);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("beat_ready", {7'd0, in_ready}, 8'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    $display("beat data=%0d last=%0d", d, l);
  endtask

  task automatic take_result();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("result_valid", {7'd0, out_valid}, 8'd1);
    $display("result sum=%0d cout=%0d count=%0d ovf=%0d", out_sum, out_cout, out_count, out_ovf);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("post_hs_valid", {7'd0, out_valid}, 8'd0);
  endtask

  task automatic chk_result(input string tag, input logic [3:0] s, input logic c,
                            input logic [3:0] cnt, input logic ovf);
    chk({tag, "_valid"}, {7'd0, out_valid}, 8'd1);
    chk({tag, "_sum"},   {4'd0, out_sum},   {4'd0, s});
    chk({tag, "_cout"},  {7'd0, out_cout},  {7'd0, c});
    chk({tag, "_count"}, {4'd0, out_count}, {4'd0, cnt});
    chk({tag, "_ovf"},   {7'd0, out_ovf},   {7'd0, ovf});
    chk({tag, "_ready"}, {7'd0, in_ready},  8'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_sum",   {4'd0, out_sum},   8'd0);
    chk("rst_count", {4'd0, out_count}, 8'd0);
    chk("rst_cout",  {7'd0, out_cout},  8'd0);
    chk("rst_ovf",   {7'd0, out_ovf},   8'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", {7'd0, in_ready}, 8'd1);

    // 10 + 5
    send(4'd10, 1'b0);
    chk("a_mid_valid", {7'd0, out_valid}, 8'd0);
    send(4'd5, 1'b1);
    chk_result("a", 4'd15, 1'b0, 4'd2, 1'b0);
    take_result();

    // 9 + 9 + 1: carry in the middle only
    send(4'd9, 1'b0);
    send(4'd9, 1'b0);
    send(4'd1, 1'b1);
    chk_result("b", 4'd3, 1'b0, 4'd3, OVF_EXP);
    take_result();

    // 11 + 15: carry on the final addition, valid right on the accepting edge
    send(4'd11, 1'b0);
    send(4'd15, 1'b1);
    chk_result("c", 4'd10, 1'b1, 4'd2, OVF_EXP);

    // Backpressure with a beat waiting upstream
    in_valid = 1'b1;
    in_data  = 4'd4;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_ready", {7'd0, in_ready},  8'd0);
      chk("bp_valid", {7'd0, out_valid}, 8'd1);
      chk("bp_sum",   {4'd0, out_sum},   8'd10);
      chk("bp_count", {4'd0, out_count}, 8'd2);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    $display("result sum=10 cout=1 count=2 taken after backpressure");
    chk("bubble_valid", {7'd0, out_valid}, 8'd0);
    chk("bubble_ready", {7'd0, in_ready},  8'd1);
    chk("bubble_count", {4'd0, out_count}, 8'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    $display("beat data=4 last=1");
    chk_result("d", 4'd4, 1'b0, 4'd1, 1'b0);
    take_result();

    // MAX_TERMS termination: fifteen 1s, no in_last
    for (int i = 0; i < 14; i++) send(4'd1, 1'b0);
    chk("e14_valid", {7'd0, out_valid}, 8'd0);
    chk("e14_count", {4'd0, out_count}, 8'd14);
    send(4'd1, 1'b0);
    chk_result("e", 4'd15, 1'b0, 4'd15, 1'b0);
    take_result();

    // Reset mid-group discards 7 + 3
    send(4'd7, 1'b0);
    send(4'd3, 1'b0);
    chk("f_mid_sum", {4'd0, out_sum}, 8'd10);
    #2 rst_n = 1'b0;
    #2;
    chk("f_rst_valid", {7'd0, out_valid}, 8'd0);
    chk("f_rst_sum",   {4'd0, out_sum},   8'd0);
    chk("f_rst_count", {4'd0, out_count}, 8'd0);
    #1 rst_n = 1'b1;
    $display("reset pulse mid-group");
    @(posedge clk);
    #1;
    chk("f_idle_valid", {7'd0, out_valid}, 8'd0);
    send(4'd2, 1'b1);
    chk_result("f", 4'd2, 1'b0, 4'd1, 1'b0);
    take_result();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
